// File: rtl/alu.sv
// Registered 32-bit ADD/SUB/AND/OR ALU with zero/negative/carry/overflow flags.
// Define ALU_SAT_EN to make ADD/SUB saturate to the signed range instead of wrapping.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  op_e              op_sel;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             arith_carry;
  logic             arith_ovf;
  logic [WIDTH-1:0] arith_result;

  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_overflow;

  assign op_sel = op_e'(op);
  assign is_sub = (op_sel == OP_SUB);

  // SUB reuses the adder as a + ~b + 1, so the carry-out is directly NOT borrow.
  assign b_eff       = is_sub ? ~b : b;
  assign sum_ext     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign sum         = sum_ext[WIDTH-1:0];
  assign arith_carry = sum_ext[WIDTH];
  assign arith_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_SAT_EN
  logic [WIDTH-1:0] sat_value;

  // On overflow the true result lies on the side of a's sign.
  assign sat_value    = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign arith_result = arith_ovf ? sat_value : sum;
`else
  assign arith_result = sum;
`endif

  always_comb begin
    next_result   = arith_result;
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    case (op_sel)
      OP_ADD, OP_SUB: begin
        next_result   = arith_result;
        next_carry    = arith_carry;
        next_overflow = arith_ovf;
      end
      OP_AND: next_result = a & b;
      OP_OR:  next_result = a | b;
      default: next_result = arith_result;
    endcase
  end

  // Result and flags only update on a valid sample; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= next_result;
        zero     <= (next_result == '0);
        negative <= next_result[WIDTH-1];
        carry    <= next_carry;
        overflow <= next_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps plus a random stream
// checked against an arithmetic reference model (honours ALU_SAT_EN).
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  logic        exp_valid;
  logic [31:0] exp_result;
  logic        exp_zero;
  logic        exp_negative;
  logic        exp_carry;
  logic        exp_overflow;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: true signed/unsigned values in 64-bit arithmetic, then clamp or wrap.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop);
    longint          sa = longint'($signed(ma));
    longint          sb = longint'($signed(mb));
    longint unsigned ua = 64'(ma);
    longint unsigned ub = 64'(mb);
    longint          true_val;
    exp_carry    = 1'b0;
    exp_overflow = 1'b0;
    case (mop)
      2'b00, 2'b01: begin
        if (mop == 2'b00) begin
          true_val   = sa + sb;
          exp_carry  = (ua + ub) > 64'hFFFF_FFFF;
          exp_result = 32'(ua + ub);
        end else begin
          true_val   = sa - sb;
          exp_carry  = (ua >= ub);
          exp_result = 32'(ua - ub);
        end
        exp_overflow = (true_val > 64'sd2147483647) || (true_val < -64'sd2147483648);
`ifdef ALU_SAT_EN
        if (exp_overflow)
          exp_result = (true_val > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      end
      2'b10:   exp_result = ma & mb;
      default: exp_result = ma | mb;
    endcase
    exp_zero     = (exp_result == 32'd0);
    exp_negative = exp_result[31];
  endtask

  task automatic model_reset();
    exp_valid    = 1'b0;
    exp_result   = 32'd0;
    exp_zero     = 1'b1;
    exp_negative = 1'b0;
    exp_carry    = 1'b0;
    exp_overflow = 1'b0;
  endtask

  task automatic check_output(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".result"},    result,         exp_result);
    check({tag, ".zero"},      32'(zero),      32'(exp_zero));
    check({tag, ".negative"},  32'(negative),  32'(exp_negative));
    check({tag, ".carry"},     32'(carry),     32'(exp_carry));
    check({tag, ".overflow"},  32'(overflow),  32'(exp_overflow));
  endtask

  // Drives one cycle of input at the falling edge, then samples 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] sa, input logic [31:0] sb,
                                input logic [1:0] sop, input string tag);
    @(negedge clk);
    in_valid = v;
    a        = sa;
    b        = sb;
    op       = sop;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) model(sa, sb, sop);
    check_output(tag);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd0;
      4:       return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;

    // Asynchronous reset between clock edges (posedge at 5, negedge at 10).
    #7;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'd0, 32'd0, 2'b00, "idle_after_reset0");
    apply_stimulus(1'b0, 32'd0, 32'd0, 2'b00, "idle_after_reset1");

    // Directed arithmetic cases with literal expectations.
    apply_stimulus(1'b1, 32'd3, 32'd2, 2'b00, "add_3_2");
    check("add_3_2.lit", result, 32'd5);
    apply_stimulus(1'b1, 32'd5, 32'd3, 2'b01, "sub_5_3");
    check("sub_5_3.lit_carry", 32'(carry), 32'd1);
    apply_stimulus(1'b1, 32'd3, 32'd3, 2'b01, "sub_3_3");
    check("sub_3_3.lit_zero", 32'(zero), 32'd1);
    apply_stimulus(1'b1, 32'd2, 32'd3, 2'b01, "sub_2_3");
    check("sub_2_3.lit", result, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 32'hC, 32'hA, 2'b10, "and_c_a");
    check("and_c_a.lit", result, 32'h8);
    apply_stimulus(1'b1, 32'hC, 32'hA, 2'b11, "or_c_a");
    check("or_c_a.lit", result, 32'hE);
    apply_stimulus(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, "add_ovf");
    check("add_ovf.lit_ovf", 32'(overflow), 32'd1);
`ifdef ALU_SAT_EN
    check("add_ovf.lit", result, 32'h7FFF_FFFF);
`else
    check("add_ovf.lit", result, 32'h8000_0000);
`endif
    apply_stimulus(1'b1, 32'h8000_0000, 32'd1, 2'b01, "sub_neg_ovf");
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00, "add_wrap");
    check("add_wrap.lit_carry", 32'(carry), 32'd1);

    // Back-to-back stream followed by a gap that must hold the last result.
    apply_stimulus(1'b1, 32'd100, 32'd23, 2'b00, "stream0");
    apply_stimulus(1'b1, 32'd100, 32'd23, 2'b01, "stream1");
    apply_stimulus(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10, "stream2");
    apply_stimulus(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11, "stream3");
    apply_stimulus(1'b0, 32'd7, 32'd9, 2'b00, "gap_hold");
    check("gap_hold.lit", result, 32'hFFF0_FFF0);

    // Reset asserted while an operation is waiting to be sampled.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'd40;
    b        = 32'd2;
    op       = 2'b00;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_output("midstream_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    apply_stimulus(1'b0, 32'd40, 32'd2, 2'b00, "post_reset_idle");
    apply_stimulus(1'b1, 32'd40, 32'd2, 2'b00, "post_reset_op");

    // Random stream with occasional gaps and boundary-biased operands.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(($urandom_range(0, 4) != 0), pick_operand(), pick_operand(),
                     2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
